block_fill_ctrl: RTL and testbench

Controller that sequences a 64-entry byte buffer and its fill counter between a byte-stream producer and a block-processing engine. It accepts bytes over a valid/ready handshake and writes them to consecutive buffer addresses. It zero-pads a short final block, hands each full block to the engine, waits for the engine to finish, then flushes the count for the next block. It sits between the input FIFO and the block engine in the datapath.

---
 rtl/blkctrl_pkg.sv | 16 +
 rtl/blk_fill_counter.sv | 31 +++
 rtl/block_fill_ctrl.sv | 146 ++++++++++++++
 tb/tb_block_fill_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/blkctrl_pkg.sv
// Shared types and defaults for the block fill controller.
// The optional watchdog is enabled with BLKCTRL_TIMEOUT_EN.
package blkctrl_pkg;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        PAD       = 2'd1,
        HANDOFF   = 2'd2,
        WAIT_DONE = 2'd3
    } blkctrl_state_t;

    localparam int          BLK_BYTES_DEF = 64;
    localparam int          ADDR_W        = $clog2(BLK_BYTES_DEF);
    localparam logic [7:0]  PAD_BYTE_DEF  = 8'h00;

endpackage

// File: rtl/blk_fill_counter.sv
// Saturating fill counter: counts buffer writes up to BLK_BYTES, cleared by flush.
module blk_fill_counter
    import blkctrl_pkg::*;
#(
    parameter int BLK_BYTES = BLK_BYTES_DEF
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         flush,
    input  logic                         inc,
    output logic [$clog2(BLK_BYTES):0]   count,
    output logic                         full
);

    localparam int CW = $clog2(BLK_BYTES) + 1;

    assign full = (count == CW'(BLK_BYTES));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/block_fill_ctrl.sv
// Sequences a byte buffer between a byte producer and a block engine: fill, pad, hand off, wait.
// Optional watchdog on the engine is enabled with BLKCTRL_TIMEOUT_EN.
module block_fill_ctrl
    import blkctrl_pkg::*;
#(
    parameter int              BLK_BYTES   = BLK_BYTES_DEF,
    parameter int              DATA_W      = 8,
    parameter logic [DATA_W-1:0] PAD_BYTE  = DATA_W'(PAD_BYTE_DEF),
    parameter int              TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         abort,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         buf_wen,
    output logic [$clog2(BLK_BYTES)-1:0] buf_waddr,
    output logic [DATA_W-1:0]            buf_wdata,
    output logic [$clog2(BLK_BYTES):0]   fill_count,
    output logic                         blk_valid,
    output logic                         blk_last,
    input  logic                         blk_ready,
    input  logic                         proc_done,
    output logic                         err_timeout
);

    localparam int BLK_AW = $clog2(BLK_BYTES);
    localparam int CW     = BLK_AW + 1;

    blkctrl_state_t         state, next_state;
    logic                   last_flag, last_nxt;
    logic                   flush;
    logic                   full;
    logic [CW-1:0]          count;
    logic                   wd_fire;

    blk_fill_counter #(.BLK_BYTES(BLK_BYTES)) u_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .flush (flush),
        .inc   (buf_wen),
        .count (count),
        .full  (full)
    );

    assign fill_count = count;
    assign buf_waddr  = count[BLK_AW-1:0];

`ifdef BLKCTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd_cnt;
    logic          err_q;

    // proc_done and abort both outrank the watchdog in its final cycle.
    assign wd_fire = (state == WAIT_DONE) && (wd_cnt == TW'(TIMEOUT_CYC - 1))
                     && !proc_done && !abort;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT_DONE) ? wd_cnt + TW'(1) : '0;
            err_q  <= wd_fire;
        end
    end

    assign err_timeout = err_q;
`else
    assign wd_fire     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= FILL;
            last_flag <= 1'b0;
        end else begin
            state     <= next_state;
            last_flag <= last_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        last_nxt   = last_flag;
        flush      = 1'b0;
        in_ready   = 1'b0;
        buf_wen    = 1'b0;
        buf_wdata  = in_data;
        blk_valid  = 1'b0;
        blk_last   = 1'b0;

        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && !full) begin
                    buf_wen = 1'b1;
                    if (count == CW'(BLK_BYTES - 1)) begin
                        next_state = HANDOFF;
                        last_nxt   = in_last;
                    end else if (in_last) begin
                        next_state = PAD;
                        last_nxt   = 1'b1;
                    end
                end
            end
            PAD: begin
                buf_wen   = !full;
                buf_wdata = PAD_BYTE;
                if (count == CW'(BLK_BYTES - 1)) begin
                    next_state = HANDOFF;
                end
            end
            HANDOFF: begin
                blk_valid = 1'b1;
                blk_last  = last_flag;
                if (blk_ready) begin
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (proc_done || wd_fire) begin
                    next_state = FILL;
                    last_nxt   = 1'b0;
                    flush      = 1'b1;
                end
            end
            default: next_state = FILL;
        endcase

        // Abort discards the block: no write this cycle, clean FILL next cycle.
        if (abort) begin
            next_state = FILL;
            last_nxt   = 1'b0;
            flush      = 1'b1;
            in_ready   = 1'b0;
            buf_wen    = 1'b0;
        end
    end

endmodule

// File: tb/tb_block_fill_ctrl.sv
// Directed self-checking bench for block_fill_ctrl (default build, BLK_BYTES=64).
module tb_block_fill_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       buf_wen;
    logic [5:0] buf_waddr;
    logic [7:0] buf_wdata;
    logic [6:0] fill_count;
    logic       blk_valid;
    logic       blk_last;
    logic       blk_ready;
    logic       proc_done;
    logic       err_timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    block_fill_ctrl dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .buf_wen     (buf_wen),
        .buf_waddr   (buf_waddr),
        .buf_wdata   (buf_wdata),
        .fill_count  (fill_count),
        .blk_valid   (blk_valid),
        .blk_last    (blk_last),
        .blk_ready   (blk_ready),
        .proc_done   (proc_done),
        .err_timeout (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input int n, input int first, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(first + i);
            in_last  = last_on_final && (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int bad;
        n_rst = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        blk_ready = 1'b0; proc_done = 1'b0;
        #12;
        check("rst_fill_count", 32'(fill_count), 32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_buf_wen",    32'(buf_wen),    32'd0);
        check("rst_blk_valid",  32'(blk_valid),  32'd0);
        check("rst_blk_last",   32'(blk_last),   32'd0);
        check("rst_err_timeout",32'(err_timeout),32'd0);
        n_rst = 1'b1;
        tick();

        // Full block 0x00..0x3F, in_last on the 64th byte.
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_last = (i == 63);
            #1;
            if (!(buf_wen === 1'b1 && buf_waddr === 6'(i) && buf_wdata === 8'(i) && in_ready === 1'b1))
                bad++;
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("full_writes_bad", 32'(bad), 32'd0);
        check("full_blk_valid",  32'(blk_valid), 32'd1);
        check("full_blk_last",   32'(blk_last),  32'd1);
        check("full_fill_count", 32'(fill_count), 32'd64);

        // Engine stalls five cycles; producer keeps offering a byte.
        bad = 0;
        in_valid = 1'b1; in_data = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!(blk_valid === 1'b1 && blk_last === 1'b1 && buf_wen === 1'b0 && in_ready === 1'b0))
                bad++;
            tick();
        end
        check("stall_stable_bad", 32'(bad), 32'd0);
        blk_ready = 1'b1;
        #1;
        check("handoff_valid", 32'(blk_valid), 32'd1);
        tick();
        blk_ready = 1'b0;
        #1;
        check("wait_blk_valid",  32'(blk_valid), 32'd0);
        check("wait_in_ready",   32'(in_ready),  32'd0);
        check("wait_buf_wen",    32'(buf_wen),   32'd0);
        check("wait_fill_count", 32'(fill_count), 32'd64);
        for (int i = 0; i < 20; i++) tick();
        check("wait_no_timeout", 32'(err_timeout), 32'd0);
        check("wait_still_held", 32'(in_ready), 32'd0);

        proc_done = 1'b1;
        #1;
        check("done_cycle_no_accept", 32'(buf_wen), 32'd0);
        tick();
        proc_done = 1'b0;
        #1;
        check("after_done_in_ready", 32'(in_ready),  32'd1);
        check("after_done_count",    32'(fill_count), 32'd0);
        check("after_done_waddr",    32'(buf_waddr), 32'd0);
        check("after_done_wen",      32'(buf_wen),   32'd1);
        check("after_done_wdata",    32'(buf_wdata), 32'hEE);
        tick();
        in_valid = 1'b0;

        // proc_done and blk_ready in FILL are ignored.
        proc_done = 1'b1; blk_ready = 1'b1;
        tick();
        proc_done = 1'b0; blk_ready = 1'b0;
        #1;
        check("fill_ignore_count", 32'(fill_count), 32'd1);
        check("fill_ignore_ready", 32'(in_ready),   32'd1);
        check("fill_ignore_valid", 32'(blk_valid),  32'd0);

        // 10-byte message (one byte already in): 54 pad bytes at 10..63.
        send_bytes(9, 8'h11, 1'b1);
        bad = 0;
        in_valid = 1'b1; in_data = 8'hFF;
        for (int i = 10; i < 64; i++) begin
            #1;
            if (!(buf_wen === 1'b1 && buf_waddr === 6'(i) && buf_wdata === 8'h00 && in_ready === 1'b0
                  && blk_valid === 1'b0))
                bad++;
            tick();
        end
        in_valid = 1'b0;
        check("pad_writes_bad",  32'(bad), 32'd0);
        check("pad_blk_valid",   32'(blk_valid), 32'd1);
        check("pad_blk_last",    32'(blk_last),  32'd1);
        check("pad_fill_count",  32'(fill_count), 32'd64);
        check("pad_no_more_wen", 32'(buf_wen), 32'd0);
        blk_ready = 1'b1; tick(); blk_ready = 1'b0;
        proc_done = 1'b1; tick(); proc_done = 1'b0;

        // Abort at fill_count=37 in FILL.
        send_bytes(37, 0, 1'b0);
        check("pre_abort_count", 32'(fill_count), 32'd37);
        in_valid = 1'b1; abort = 1'b1;
        #1;
        check("abort_no_write", 32'(buf_wen), 32'd0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        #1;
        check("abort_fill_count", 32'(fill_count), 32'd0);
        check("abort_blk_valid",  32'(blk_valid),  32'd0);
        check("abort_in_ready",   32'(in_ready),   32'd1);

        // Abort in HANDOFF retracts blk_valid; block has no in_last.
        send_bytes(64, 8'h40, 1'b0);
        check("ho_blk_valid", 32'(blk_valid), 32'd1);
        check("ho_blk_last",  32'(blk_last),  32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check("ho_abort_count",    32'(fill_count), 32'd0);
        check("ho_abort_blk_valid",32'(blk_valid),  32'd0);
        check("ho_abort_in_ready", 32'(in_ready),   32'd1);
        in_valid = 1'b1; in_data = 8'h5A;
        #1;
        check("ho_abort_next_addr", 32'(buf_waddr), 32'd0);
        tick();
        in_valid = 1'b0;

        // Asynchronous reset mid-block.
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_count", 32'(fill_count), 32'd0);
        n_rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
